// File: rtl/led_pattern_gen.sv
// led_pattern_gen
// Animated test-pattern generator for the red/green LED matrix. It drives
// one of four timed images: corner markers, a walking pixel, a toggling
// checkerboard or a row fill. Pixels and Frame are registered from the
// pattern state, so the image lags the state by one clock.
//
// Optional feature: define LED_PATTERN_STEP_EN to add the Step input. A
// rising edge on Step forces a single animation tick.
module led_pattern_gen #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int TICK_DIV = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      Enable,
    input  logic [1:0]                Mode,
`ifdef LED_PATTERN_STEP_EN
    input  logic                      Step,
`endif
    output logic [ROWS-1:0][COLS-1:0] RedPixels,
    output logic [ROWS-1:0][COLS-1:0] GrnPixels,
    output logic                      Frame
);

    localparam int NPIX  = ROWS * COLS;
    localparam int POS_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [POS_W-1:0] POS_LAST_PIX = POS_W'(NPIX - 1);
    localparam logic [POS_W-1:0] POS_LAST_ROW = POS_W'(ROWS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_CORNERS = 2'd0,
        MODE_WALK    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_FILL    = 2'd3
    } mode_t;

    // Pattern state
    mode_t            mode_q;
    logic [DIV_W-1:0] div_q;
    logic [POS_W-1:0] pos_q;
    logic             phase_q;
    // Set on the tick that wraps a sequence; becomes Frame together with the
    // image that shows the wrapped state.
    logic             wrap_q;

    mode_t            mode_in;
    logic             mode_change;
    logic             tick;

    logic [ROWS-1:0][COLS-1:0] red_img;
    logic [ROWS-1:0][COLS-1:0] grn_img;

    assign mode_in     = mode_t'(Mode);
    assign mode_change = (mode_in != mode_q);

`ifdef LED_PATTERN_STEP_EN
    logic step_q;
    logic step_rise;

    // Previous Step level for edge detection; tracked even while disabled so
    // an edge seen during Enable=0 is consumed rather than replayed later.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            step_q <= 1'b0;
        end else begin
            step_q <= Step;
        end
    end

    assign step_rise = Step & ~step_q;
    // A step coinciding with a natural divider tick still yields one tick.
    assign tick      = (div_q == DIV_LAST) | step_rise;
`else
    assign tick      = (div_q == DIV_LAST);
`endif

    // Advance divider, position and phase; a mode change restarts the pattern.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q  <= MODE_CORNERS;
            div_q   <= '0;
            pos_q   <= '0;
            phase_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (Enable) begin
            // NOTE: state registers use non-blocking assignments so every
            // branch below sees the pre-edge values of div_q/pos_q/phase_q.
            mode_q <= mode_in;
            wrap_q <= 1'b0;
            if (mode_change) begin
                div_q   <= '0;
                pos_q   <= '0;
                phase_q <= 1'b0;
            end else if (tick) begin
                div_q <= '0;
                case (mode_q)
                    MODE_CORNERS: begin
                        wrap_q <= 1'b1;
                    end
                    MODE_WALK: begin
                        if (pos_q == POS_LAST_PIX) begin
                            pos_q   <= '0;
                            phase_q <= ~phase_q;
                            wrap_q  <= 1'b1;
                        end else begin
                            pos_q <= pos_q + 1'b1;
                        end
                    end
                    MODE_CHECKER: begin
                        phase_q <= ~phase_q;
                        // Wraps on the tick that brings phase back to 0.
                        wrap_q  <= phase_q;
                    end
                    MODE_FILL: begin
                        if (pos_q == POS_LAST_ROW) begin
                            pos_q  <= '0;
                            wrap_q <= 1'b1;
                        end else begin
                            pos_q <= pos_q + 1'b1;
                        end
                    end
                endcase
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    // Render the image for the current pattern state.
    always_comb begin
        // NOTE: both images get a full default first so no path through the
        // case/loops leaves a bit unassigned and infers a latch.
        red_img = '0;
        grn_img = '0;
        case (mode_q)
            MODE_CORNERS: begin
                red_img[0][0]             = 1'b1;
                red_img[ROWS-1][0]        = 1'b1;
                grn_img[0][COLS-1]        = 1'b1;
                grn_img[ROWS-1][COLS-1]   = 1'b1;
            end
            MODE_WALK: begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        if (pos_q == POS_W'(r * COLS + c)) begin
                            red_img[r][c] = ~phase_q;
                            grn_img[r][c] = phase_q;
                        end
                    end
                end
            end
            MODE_CHECKER: begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        red_img[r][c] = (((r + c) % 2) == 0) ^ phase_q;
                        grn_img[r][c] = ~red_img[r][c];
                    end
                end
            end
            MODE_FILL: begin
                for (int r = 0; r < ROWS; r++) begin
                    if (POS_W'(r) <= pos_q) begin
                        red_img[r] = '1;
                        grn_img[r] = '1;
                    end
                end
            end
        endcase
    end

    // Register the image and Frame; both hold/clear while disabled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the pixel arrays are plain flops driving LEDs, not a RAM,
            // so they are reset to keep the matrix dark until the first image.
            RedPixels <= '0;
            GrnPixels <= '0;
            Frame     <= 1'b0;
        end else begin
            Frame <= Enable & wrap_q;
            if (Enable) begin
                RedPixels <= red_img;
                GrnPixels <= grn_img;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen (ROWS=COLS=16, TICK_DIV=4). A cycle model
// predicts the registered outputs; each prediction is queued when the
// inputs for a cycle are driven and compared once the DUT has clocked.
// With LED_PATTERN_STEP_EN a second instance (TICK_DIV=1000) covers Step.
module tb_led_pattern_gen;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int TD   = 4;
    localparam int NPIX = ROWS * COLS;

    typedef logic [ROWS-1:0][COLS-1:0] img_t;
    typedef struct packed {
        img_t red;
        img_t grn;
        logic frame;
    } obs_t;

    logic       CLK    = 1'b0;
    logic       RST_N  = 1'b0;
    logic       Enable = 1'b0;
    logic [1:0] Mode   = 2'd0;
    img_t       RedPixels;
    img_t       GrnPixels;
    logic       Frame;

    int errors = 0;
    int checks = 0;

    obs_t sb_q[$];

    // Model state
    int   m_mode;
    int   m_div;
    int   m_pos;
    logic m_phase;
    logic m_wrap;
    img_t exp_red;
    img_t exp_grn;
    logic exp_frame;

    always #5 CLK = ~CLK;

`ifdef LED_PATTERN_STEP_EN
    logic main_step = 1'b0;
`endif

    led_pattern_gen #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TD)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Enable   (Enable),
        .Mode     (Mode),
`ifdef LED_PATTERN_STEP_EN
        .Step     (main_step),
`endif
        .RedPixels(RedPixels),
        .GrnPixels(GrnPixels),
        .Frame    (Frame)
    );

`ifdef LED_PATTERN_STEP_EN
    logic       s_en   = 1'b0;
    logic [1:0] s_mode = 2'd0;
    logic       s_step = 1'b0;
    img_t       s_red;
    img_t       s_grn;
    logic       s_frame;

    led_pattern_gen #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(1000)) dut_step (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Enable   (s_en),
        .Mode     (s_mode),
        .Step     (s_step),
        .RedPixels(s_red),
        .GrnPixels(s_grn),
        .Frame    (s_frame)
    );
`endif

    // Image expected for a given pattern state.
    function automatic obs_t draw(int md, int pos, logic ph);
        obs_t o;
        int   row;
        int   col;
        o = '0;
        case (md)
            0: begin
                o.red[0][0]           = 1'b1;
                o.red[ROWS-1][0]      = 1'b1;
                o.grn[0][COLS-1]      = 1'b1;
                o.grn[ROWS-1][COLS-1] = 1'b1;
            end
            1: begin
                row = pos / COLS;
                col = pos % COLS;
                if (ph) o.grn[row][col] = 1'b1;
                else    o.red[row][col] = 1'b1;
            end
            2: begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        if ((r + c + int'(ph)) % 2 == 0) o.red[r][c] = 1'b1;
                        else                             o.grn[r][c] = 1'b1;
            end
            default: begin
                for (int r = 0; r <= pos; r++) begin
                    o.red[r] = '1;
                    o.grn[r] = '1;
                end
            end
        endcase
        return o;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_div = 0; m_pos = 0; m_phase = 1'b0; m_wrap = 1'b0;
        exp_red = '0; exp_grn = '0; exp_frame = 1'b0;
    endtask

    // Outputs expected after the coming rising edge, given current inputs.
    task automatic model_clock();
        obs_t img;
        if (Enable) begin
            img       = draw(m_mode, m_pos, m_phase);
            exp_red   = img.red;
            exp_grn   = img.grn;
            exp_frame = m_wrap;
            m_wrap    = 1'b0;
            if (int'(Mode) != m_mode) begin
                m_mode = int'(Mode); m_div = 0; m_pos = 0; m_phase = 1'b0;
            end else if (m_div == TD - 1) begin
                m_div = 0;
                case (m_mode)
                    0: m_wrap = 1'b1;
                    1: if (m_pos == NPIX - 1) begin
                           m_pos = 0; m_phase = ~m_phase; m_wrap = 1'b1;
                       end else m_pos++;
                    2: begin m_phase = ~m_phase; m_wrap = !m_phase; end
                    default: if (m_pos == ROWS - 1) begin
                           m_pos = 0; m_wrap = 1'b1;
                       end else m_pos++;
                endcase
            end else begin
                m_div++;
            end
        end else begin
            exp_frame = 1'b0;
        end
    endtask

    // One clock: predict and queue, clock the DUT, then compare at negedge.
    task automatic sb_cycle();
        obs_t e;
        model_clock();
        e.red = exp_red; e.grn = exp_grn; e.frame = exp_frame;
        sb_q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        e = sb_q.pop_front();
        checks++;
        if ({RedPixels, GrnPixels} !== {e.red, e.grn}) begin
            errors++;
            $display("FAIL sb_pixels t=%0t red=%h grn=%h expected red=%h grn=%h",
                     $time, RedPixels, GrnPixels, e.red, e.grn);
        end
        checks++;
        if (Frame !== e.frame) begin
            errors++;
            $display("FAIL sb_frame t=%0t got=%b expected=%b", $time, Frame, e.frame);
        end
    endtask

    task automatic test_reset();
        img_t er;
        img_t eg;
        RST_N = 1'b0; Enable = 1'b1; Mode = 2'd0;
        repeat (2) @(negedge CLK);
        checks++;
        if (RedPixels !== '0 || GrnPixels !== '0 || Frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold red=%h grn=%h frame=%b expected all zero",
                     RedPixels, GrnPixels, Frame);
        end
        model_reset();
        RST_N = 1'b1;
        sb_cycle();
        er = '0; er[0][0] = 1'b1; er[ROWS-1][0] = 1'b1;
        eg = '0; eg[0][COLS-1] = 1'b1; eg[ROWS-1][COLS-1] = 1'b1;
        checks++;
        if (RedPixels !== er || GrnPixels !== eg) begin
            errors++;
            $display("FAIL reset_corners red=%h grn=%h expected red=%h grn=%h",
                     RedPixels, GrnPixels, er, eg);
        end
    endtask

    task automatic test_corners();
        int frames = 0;
        for (int i = 0; i < 12; i++) begin
            sb_cycle();
            if (Frame === 1'b1) frames++;
        end
        checks++;
        if (frames != 3) begin
            errors++;
            $display("FAIL corners_frames got=%0d expected=3", frames);
        end
    endtask

    task automatic test_walk();
        int frames = 0;
        Mode = 2'd1;
        for (int i = 0; i < 1026; i++) begin
            sb_cycle();
            if (i > 0 && Frame === 1'b1) frames++;
        end
        checks++;
        if (frames != 1 || Frame !== 1'b1) begin
            errors++;
            $display("FAIL walk_wrap_frame frames=%0d last=%b expected frames=1 last=1",
                     frames, Frame);
        end
        checks++;
        if (GrnPixels[0][0] !== 1'b1 || $countones(GrnPixels) != 1 || RedPixels !== '0) begin
            errors++;
            $display("FAIL walk_wrap_green red=%h grn=%h expected single green at [0][0]",
                     RedPixels, GrnPixels);
        end
    endtask

    task automatic test_checker();
        int frames = 0;
        Mode = 2'd2;
        sb_cycle();
        sb_cycle();
        checks++;
        if (RedPixels[0][0] !== 1'b1 || GrnPixels[0][1] !== 1'b1 || RedPixels[0][1] !== 1'b0) begin
            errors++;
            $display("FAIL checker_phase0 r00=%b g01=%b r01=%b expected 1 1 0",
                     RedPixels[0][0], GrnPixels[0][1], RedPixels[0][1]);
        end
        repeat (4) sb_cycle();
        checks++;
        if (RedPixels[0][0] !== 1'b0 || GrnPixels[0][0] !== 1'b1 || RedPixels[0][1] !== 1'b1) begin
            errors++;
            $display("FAIL checker_swap r00=%b g00=%b r01=%b expected 0 1 1",
                     RedPixels[0][0], GrnPixels[0][0], RedPixels[0][1]);
        end
        for (int i = 0; i < 32; i++) begin
            sb_cycle();
            if (Frame === 1'b1) frames++;
        end
        checks++;
        if (frames != 4) begin
            errors++;
            $display("FAIL checker_frames got=%0d expected=4", frames);
        end
    endtask

    task automatic test_fill_freeze();
        img_t held_red;
        img_t held_grn;
        img_t row0;
        logic prev_row15 = 1'b0;
        logic found      = 1'b0;
        Mode = 2'd3;
        repeat (21) sb_cycle();
        held_red = exp_red;
        held_grn = exp_grn;
        Enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sb_cycle();
            checks++;
            if (Frame !== 1'b0 || RedPixels !== held_red || GrnPixels !== held_grn) begin
                errors++;
                $display("FAIL freeze_hold cycle=%0d frame=%b red=%h expected frame=0 red=%h",
                         i, Frame, RedPixels, held_red);
            end
        end
        Enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            sb_cycle();
            if (Frame === 1'b1) begin
                found = 1'b1;
                break;
            end
            prev_row15 = (RedPixels[ROWS-1] === '1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL fill_frame_timeout got=no_frame expected=frame within 200 cycles");
        end
        row0 = '0;
        row0[0] = '1;
        checks++;
        if (RedPixels !== row0 || GrnPixels !== row0 || prev_row15 !== 1'b1) begin
            errors++;
            $display("FAIL fill_wrap red=%h grn=%h prev_row15=%b expected red=grn=%h prev_row15=1",
                     RedPixels, GrnPixels, prev_row15, row0);
        end
    endtask

    task automatic test_mode_change();
        img_t chk_red;
        Mode = 2'd1;
        for (int i = 0; i < 400; i++) begin
            sb_cycle();
            if (m_pos == 37 && m_div == 2) break;
        end
        checks++;
        if (RedPixels[2][5] !== 1'b1 || $countones(RedPixels) != 1) begin
            errors++;
            $display("FAIL walk_pos37 red=%h expected single red at [2][5]", RedPixels);
        end
        Mode = 2'd2;
        sb_cycle();
        checks++;
        if (Frame !== 1'b0) begin
            errors++;
            $display("FAIL mode_change_frame0 got=%b expected=0", Frame);
        end
        sb_cycle();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                chk_red[r][c] = ((r + c) % 2 == 0);
        checks++;
        if (Frame !== 1'b0 || RedPixels !== chk_red || GrnPixels !== ~chk_red) begin
            errors++;
            $display("FAIL mode_change_restart frame=%b red=%h expected frame=0 red=%h",
                     Frame, RedPixels, chk_red);
        end
        repeat (3) sb_cycle();
        checks++;
        if (RedPixels[0][0] !== 1'b1) begin
            errors++;
            $display("FAIL mode_change_div_hold r00=%b expected=1", RedPixels[0][0]);
        end
        sb_cycle();
        checks++;
        if (RedPixels[0][0] !== 1'b0) begin
            errors++;
            $display("FAIL mode_change_div_tick r00=%b expected=0", RedPixels[0][0]);
        end
    endtask

    task automatic test_reset_mid();
        Mode = 2'd1;
        repeat (30) sb_cycle();
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (RedPixels !== '0 || GrnPixels !== '0 || Frame !== 1'b0) begin
            errors++;
            $display("FAIL async_reset red=%h grn=%h frame=%b expected all zero",
                     RedPixels, GrnPixels, Frame);
        end
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        sb_cycle();
        sb_cycle();
        checks++;
        if (RedPixels[0][0] !== 1'b1 || $countones(RedPixels) != 1 || GrnPixels !== '0) begin
            errors++;
            $display("FAIL reset_restart red=%h grn=%h expected single red at [0][0]",
                     RedPixels, GrnPixels);
        end
    endtask

`ifdef LED_PATTERN_STEP_EN
    task automatic test_step();
        RST_N = 1'b0; s_en = 1'b1; s_mode = 2'd1; s_step = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            s_step = 1'b1;
            @(negedge CLK);
            s_step = 1'b0;
            @(negedge CLK);
        end
        checks++;
        if (s_red[0][3] !== 1'b1 || $countones(s_red) != 1 || s_grn !== '0) begin
            errors++;
            $display("FAIL step_pulses red=%h grn=%h expected single red at [0][3]", s_red, s_grn);
        end
        s_step = 1'b1;
        repeat (5) @(negedge CLK);
        s_step = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (s_red[0][4] !== 1'b1 || $countones(s_red) != 1) begin
            errors++;
            $display("FAIL step_held red=%h expected single red at [0][4]", s_red);
        end
        s_en = 1'b0;
        s_step = 1'b1;
        @(negedge CLK);
        s_step = 1'b0;
        @(negedge CLK);
        s_en = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (s_red[0][4] !== 1'b1 || $countones(s_red) != 1) begin
            errors++;
            $display("FAIL step_disabled red=%h expected single red at [0][4]", s_red);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t expected bench to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(negedge CLK);
        test_reset();
        test_corners();
        test_walk();
        test_checker();
        test_fill_freeze();
        test_mode_change();
        test_reset_mid();
`ifdef LED_PATTERN_STEP_EN
        test_step();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
